// File: rtl/div_sequencer.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Returns quotient and remainder; divide by zero yields an all-ones quotient and flags it.
module div_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6   // must satisfy 2**CNT_W > WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   prem_q, prem_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               qbit;

    always_comb begin
        // Keep the partial remainder's top bit so divisors with the MSB set stay exact.
        shifted = {prem_q, shift_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr_q};
        qbit    = ~trial[WIDTH];

        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        shift_d = shift_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvsr_d = divisor;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d   = CNT_W'(WIDTH - 1);
                        prem_d  = '0;
                        shift_d = dividend;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                prem_d  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                shift_d = {shift_q[WIDTH-2:0], qbit};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    // Results only move on completion so they hold through the next RUN.
                    quot_d  = shift_d;
                    rem_d   = prem_d;
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prem_q  <= '0;
            shift_q <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            shift_q <= shift_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomised checks of div_sequencer: latency, results, hold, start gating, reset.
module tb_div_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;
    localparam int          NORM_LAT = WIDTH + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Issue one request, scramble operands after acceptance, return at the done cycle.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output logic busy1, output logic [WIDTH-1:0] mid_q);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = ~a;
        divisor = b ^ 32'h5A5A_A5A5;
        busy1 = busy;
        mid_q = quotient;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 10) mid_q = quotient;
        end
    endtask

    task automatic test_reset();
        int lat;
        logic b1;
        logic [WIDTH-1:0] mq;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_init: busy=%b done=%b dbz=%b q=%h r=%h required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        reset_n = 1'b1;
        run_op(20, 6, lat, b1, mq);
        checks++;
        if (quotient !== 32'd3 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL reset_preop: q=%0d r=%0d required q=3 r=2", quotient, remainder);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_async: busy=%b done=%b dbz=%b q=%h r=%h required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        logic b1;
        logic [WIDTH-1:0] mq;
        run_op(100, 7, lat, b1, mq);
        checks++;
        if (b1 !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: busy=%b required 1", b1);
        end
        checks++;
        if (lat != NORM_LAT) begin
            failures++;
            $display("FAIL basic_latency: got %0d required %0d", lat, NORM_LAT);
        end
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b required 14 2 0",
                     quotient, remainder, div_by_zero);
        end
        checks++;
        if (mq !== 32'd0) begin
            failures++;
            $display("FAIL basic_hold_during_run: q=%h required 0", mq);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_after_done: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic b1;
        logic [WIDTH-1:0] mq;
        run_op(32'h1234_5678, 32'd0, lat, b1, mq);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL dbz_latency: got %0d required 1", lat);
        end
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result: q=%h r=%h dbz=%b required ffffffff 12345678 1",
                     quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL dbz_after: done=%b busy=%b q=%h required 0 0 ffffffff",
                     done, busy, quotient);
        end
    endtask

    task automatic test_boundaries();
        logic [WIDTH-1:0] va [5] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        logic [WIDTH-1:0] vb [5] = '{32'd1, 32'd9, 32'hFFFF_FFFF, 32'd3, 32'h8000_0001};
        logic [WIDTH-1:0] vq [5] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'd1};
        logic [WIDTH-1:0] vr [5] = '{32'd0, 32'd5, 32'd0, 32'd0, 32'h7FFF_FFFE};
        int lat;
        logic b1;
        logic [WIDTH-1:0] mq;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], lat, b1, mq);
            checks++;
            if (quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0
                || lat != NORM_LAT) begin
                failures++;
                $display("FAIL boundary_%0d: %h/%h q=%h r=%h dbz=%b lat=%0d required q=%h r=%h 0 %0d",
                         i, va[i], vb[i], quotient, remainder, div_by_zero, lat,
                         vq[i], vr[i], NORM_LAT);
            end
        end
    endtask

    task automatic test_start_during_busy();
        int lat;
        @(negedge clk);
        start = 1'b1;
        dividend = 100;
        divisor = 7;
        @(negedge clk);
        dividend = 50;
        divisor = 5;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != NORM_LAT || quotient !== 32'd14 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL busy_first: lat=%0d q=%0d r=%0d required %0d 14 2",
                     lat, quotient, remainder, NORM_LAT);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL busy_idle_gap: busy=%b done=%b required 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_second_accept: busy=%b required 1", busy);
        end
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != NORM_LAT || quotient !== 32'd10 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL busy_second: lat=%0d q=%0d r=%0d required %0d 10 0",
                     lat, quotient, remainder, NORM_LAT);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic b1;
        logic saw_done;
        logic [WIDTH-1:0] mq;
        @(negedge clk);
        start = 1'b1;
        dividend = 1000;
        divisor = 3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL midrun_clear: busy=%b done=%b dbz=%b q=%h r=%h required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        repeat (WIDTH) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_done: saw_done=%b required 0", saw_done);
        end
        run_op(1000, 3, lat, b1, mq);
        checks++;
        if (lat != NORM_LAT || quotient !== 32'd333 || remainder !== 32'd1) begin
            failures++;
            $display("FAIL midrun_fresh: lat=%0d q=%0d r=%0d required %0d 333 1",
                     lat, quotient, remainder, NORM_LAT);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, eq, er;
        logic [63:0] recon;
        int lat, sel, elat;
        logic b1;
        logic [WIDTH-1:0] mq;
        for (int n = 0; n < 1500; n++) begin
            a = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel == 1) b = 32'd1;
            else if (sel <= 4) b = $urandom;
            else b = $urandom >> $urandom_range(1, 31);
            if (b == '0) begin
                eq = '1;
                er = a;
                elat = 1;
            end else begin
                eq = a / b;
                er = a % b;
                elat = NORM_LAT;
            end
            run_op(a, b, lat, b1, mq);
            checks++;
            if (quotient !== eq || remainder !== er || div_by_zero !== (b == '0)
                || lat != elat) begin
                failures++;
                $display("FAIL rand_%0d: %h/%h q=%h r=%h dbz=%b lat=%0d required %h %h %b %0d",
                         n, a, b, quotient, remainder, div_by_zero, lat, eq, er, b == '0, elat);
            end
            if (b != '0) begin
                recon = 64'(quotient) * 64'(b) + 64'(remainder);
                checks++;
                if (recon !== 64'(a) || remainder >= b) begin
                    failures++;
                    $display("FAIL rand_invariant_%0d: q*d+r=%h r=%h required %h and r<%h",
                             n, recon, remainder, a, b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_start_during_busy();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
